sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parameterised FIFO and the same-clock counterpart to the existing dual-clock FIFO. It keeps the familiar flag set (full, empty, has_data) and the RESERVE headroom, and it holds reset for a fixed number of cycles. It adds a selectable first-word-fall-through read mode, an occupancy count, and sticky overflow/underflow error flags. It is used wherever producer and consumer share a clock, such as packet staging and stream rate-matching.

## Interface
- DATA_WIDTH, default 8: word width.
- ADDR_WIDTH, default 4: DEPTH = 2**ADDR_WIDTH words of storage capacity.
- RESERVE, default 0: full asserts when count >= DEPTH-RESERVE. Legal range is 0..DEPTH-1.
- FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
- RST_CYCLES, default 8: internal reset hold length after rst deasserts. Minimum value is 1.

Ports:
- clk  in  1: single clock; all logic on its rising edge.
- rst  in  1: reset; synchronous, active-high.
- wr_en  in  1: write request.
- wr_data  in  DATA_WIDTH: write word.
- full  out  1: RESERVE threshold reached, or reset in progress.
- rd_en  in  1: read/pop request.
- rd_data  out  DATA_WIDTH: read word.
- empty  out  1: no readable word.
- has_data  out  1: readable word available (FWFT=1: rd_data is valid).
- count  out  ADDR_WIDTH+1: words held, including any word in the FWFT output register.
- overflow  out  1: sticky; a write was attempted with count==DEPTH.
- underflow  out  1: sticky; a read was attempted with has_data=0.
- rst_busy  out  1: internal reset active.

## Operation
Reset and internal reset:
- Internal reset holds while rst is high, and for RST_CYCLES edges after rst is first sampled low.
- While internal reset holds: pointers=0, count=0, full=1, empty=1, has_data=0, rd_data=0, overflow=0, underflow=0, rst_busy=1.
- During internal reset, wr_en and rd_en are ignored and do not set the error flags.
- Asserting rst mid-operation discards all contents. A 1-cycle rst pulse still produces the full RST_CYCLES hold.

Write:
- A write is accepted on any edge with wr_en=1 and count<DEPTH.
- full is an early warning only. With RESERVE>0, writes continue to be accepted between the threshold and DEPTH.
- wr_en=1 with count==DEPTH drops the word and sets overflow. This applies even if a read pops on the same edge.

Read, FWFT=0:
- rd_en=1 with has_data=1 pops the head word. rd_data is loaded at that edge and holds until the next pop.

Read, FWFT=1:
- The head word is moved into an output register and is presented on rd_data while has_data=1.
- rd_en=1 with has_data=1 pops it. The next word, if present, appears on rd_data the following cycle.

Error and pointer rules:
- rd_en=1 with has_data=0 is ignored and sets underflow.
- An accepted write and an accepted pop on the same edge leave count unchanged.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- count uses modulo-free arithmetic and never exceeds DEPTH.

Flags:
- Flags are registered, derived from next-state count.
- empty = !has_data at all times.

## Timing
Reset:
- rst sampled low at edge E: rst_busy=0 and full=0 after edge E+RST_CYCLES. The first write can be accepted at edge E+RST_CYCLES+1.

Write to read visibility:
- Write accepted at edge N: count is incremented after edge N.
- FWFT=0: has_data=1 after edge N.
- FWFT=1: rd_data is valid and has_data=1 after edge N+1.

Read, FWFT=0:
- Pop at edge N: rd_data updates after edge N. This is 1-cycle read latency.
- Back-to-back pops on consecutive edges stream one word per cycle.

Read, FWFT=1:
- Continuous rd_en with words available gives one word per cycle, with no bubble.

Throughput and flags:
- Sustained throughput is one write plus one read per cycle.
- full, empty, has_data and count all change on the same edge.
- overflow and underflow set on the edge of the offending request and stay set until internal reset.

## Test plan
- Reset release timing: rst high for 20 cycles, then low → rst_busy stays 1 for exactly RST_CYCLES=8 edges. full=1 and count=0 throughout the hold; full=0 after the hold.
- Ordering, FWFT=0: write 100..107, then pop 8 times → rd_data=100..107 in order, each one cycle after its pop. empty=1 after the 8th pop.
- Ordering, FWFT=1: write 0xA0..0xA3 → rd_data=0xA0 with has_data=1 two cycles after the first write. Continuous rd_en returns 0xA0..0xA3 on consecutive cycles.
- Full, overflow and RESERVE: RESERVE=2, DEPTH=16, write 17 words → full=1 at count=14, while writes 15 and 16 are accepted. The 17th write is dropped, overflow=1, count=16.
- Underflow and simultaneous access:
  - Pop while empty → underflow=1, count stays 0.
  - At count=5, assert wr_en and rd_en together for 20 cycles → count stays 5, data order is preserved, and the pointers wrap past 15.
- Reset mid-stream: with 8 words held and wr_en/rd_en active, apply a 2-cycle rst → count=0, empty=1, overflow=0, underflow=0. A subsequent write/read of 0x55 returns 0x55.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, RESERVE-based early full warning and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 0,
  parameter int FWFT       = 0,
  parameter int RST_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  rst_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int RW    = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - RESERVE);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic                  ov_q, ov_d;
  logic                  full_q, full_d, has_q, has_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, pop, ram_rd;

  always_comb begin
    wr_acc    = !busy_q && wr_en && (count_q < DEPTH_C);
    pop       = !busy_q && rd_en && has_q;
    ram_rd    = 1'b0;
    ov_d      = ov_q;
    rd_data_d = rd_data_q;
    // In FWFT mode the output register is refilled from RAM whenever it is
    // empty or being popped, so continuous reads stream without a bubble.
    if (FWFT != 0) begin
      ram_rd = (ram_cnt_q != '0) && (!ov_q || pop);
      if (ram_rd) begin
        ov_d      = 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end else if (pop) begin
        ov_d = 1'b0;
      end
    end else begin
      ram_rd = pop;
      if (pop) rd_data_d = mem_q[rd_ptr_q];
    end
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(ram_rd);
    ram_cnt_d = ram_cnt_q + CW'(wr_acc) - CW'(ram_rd);
    count_d   = ram_cnt_d + CW'(ov_d);
    has_d     = (FWFT != 0) ? ov_d : (ram_cnt_d != '0);
    ovf_d     = ovf_q | (!busy_q && wr_en && (count_q == DEPTH_C));
    udf_d     = udf_q | (!busy_q && rd_en && !has_q);
    busy_d    = (rst_cnt_q != '0);
    rst_cnt_d = (rst_cnt_q != '0) ? rst_cnt_q - RW'(1) : '0;
    full_d    = busy_d || (count_d >= FULL_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_q <= RW'(RST_CYCLES);
      busy_q    <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      ov_q      <= 1'b0;
      full_q    <= 1'b1;
      has_q     <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      ov_q      <= ov_d;
      full_q    <= full_d;
      has_q     <= has_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full      = full_q;
  assign rd_data   = rd_data_q;
  assign has_data  = has_q;
  assign empty     = !has_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign rst_busy  = busy_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance with RESERVE=2 and
// a first-word-fall-through instance, sharing clock and reset.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic [7:0] wr_data0 = '0, rd_data0;
  logic       full0, empty0, has0, ovf0, udf0, busy0;
  logic [4:0] count0;

  logic       wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [7:0] wr_data1 = '0, rd_data1;
  logic       full1, empty1, has1, ovf1, udf1, busy1;
  logic [4:0] count1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(2), .FWFT(0), .RST_CYCLES(8)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .full(full0),
    .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0), .has_data(has0),
    .count(count0), .overflow(ovf0), .underflow(udf0), .rst_busy(busy0));

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(0), .FWFT(1), .RST_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .full(full1),
    .rd_en(rd_en1), .rd_data(rd_data1), .empty(empty1), .has_data(has1),
    .count(count1), .overflow(ovf1), .underflow(udf1), .rst_busy(busy1));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       full;
    logic       has;
    logic [7:0] dout;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic rd, input int din, input int cnt,
                              input logic fl, input logic hs, input int dout,
                              input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = 8'(din); v.cnt = 5'(cnt);
    v.full = fl; v.has = hs; v.dout = 8'(dout); v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;

    // Vector table for the registered-read instance.
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(1, 0, 100 + i, i + 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 7 - i, 0, (i < 7), 100 + i, 0, 1);
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i < 16) ? i + 1 : 16;
      add(1, 0, 200 + i, c, (c >= 14), 1, 107, (i == 16), 1);
    end
    for (int i = 0; i < 16; i++) add(0, 1, 0, 15 - i, ((15 - i) >= 14), (i < 15), 200 + i, 1, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 50 + i, i + 1, 0, 1, 215, 1, 1);
    for (int i = 0; i < 20; i++) add(1, 1, 55 + i, 5, 0, 1, 50 + i, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 75 + i, 6 + i, 0, 1, 69, 1, 1);

    // Reset release: hold rst for 20 cycles, then count the internal hold.
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst busy", busy0, 1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("hold%0d busy", k), busy0, 1);
      chk($sformatf("hold%0d full", k), full0, 1);
      chk($sformatf("hold%0d count", k), count0, 0);
    end
    step();
    chk("release busy", busy0, 0);
    chk("release full", full0, 0);
    chk("release empty", empty0, 1);
    chk("release busy fwft", busy1, 0);

    foreach (vecs[i]) begin
      wr_en0 = vecs[i].wr;
      rd_en0 = vecs[i].rd;
      wr_data0 = vecs[i].din;
      step();
      chk($sformatf("v%0d count", i), count0, vecs[i].cnt);
      chk($sformatf("v%0d full", i), full0, vecs[i].full);
      chk($sformatf("v%0d has_data", i), has0, vecs[i].has);
      chk($sformatf("v%0d empty", i), empty0, !vecs[i].has);
      chk($sformatf("v%0d rd_data", i), rd_data0, vecs[i].dout);
      chk($sformatf("v%0d overflow", i), ovf0, vecs[i].ovf);
      chk($sformatf("v%0d underflow", i), udf0, vecs[i].udf);
    end
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;

    // FWFT instance: underflow, then fall-through latency and streaming.
    rd_en1 = 1'b1;
    step();
    rd_en1 = 1'b0;
    chk("fwft underflow", udf1, 1);
    chk("fwft udf count", count1, 0);
    for (int i = 0; i < 4; i++) begin
      wr_en1 = 1'b1;
      wr_data1 = 8'hA0 + 8'(i);
      step();
      if (i == 0) begin
        chk("fwft w0 has_data", has1, 0);
        chk("fwft w0 count", count1, 1);
      end
      if (i == 1) begin
        chk("fwft w1 has_data", has1, 1);
        chk("fwft w1 rd_data", rd_data1, 8'hA0);
      end
    end
    wr_en1 = 1'b0;
    chk("fwft count4", count1, 4);
    chk("fwft head", rd_data1, 8'hA0);
    rd_en1 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("fwft pop%0d rd_data", i), rd_data1, 8'hA0 + 8'(i));
      chk($sformatf("fwft pop%0d has_data", i), has1, 1);
    end
    step();
    rd_en1 = 1'b0;
    chk("fwft drained has_data", has1, 0);
    chk("fwft drained count", count1, 0);

    // Mid-stream reset with 8 words held and both requests active.
    chk("pre-rst count", count0, 8);
    wr_en0 = 1'b1;
    rd_en0 = 1'b1;
    wr_data0 = 8'h99;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (!busy0) done = 1'b1;
    end
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    chk("mid-rst hold ended", done, 1);
    chk("mid-rst count", count0, 0);
    chk("mid-rst empty", empty0, 1);
    chk("mid-rst overflow", ovf0, 0);
    chk("mid-rst underflow", udf0, 0);
    wr_en0 = 1'b1;
    wr_data0 = 8'h55;
    step();
    wr_en0 = 1'b0;
    chk("post-rst write count", count0, 1);
    rd_en0 = 1'b1;
    step();
    rd_en0 = 1'b0;
    chk("post-rst rd_data", rd_data0, 8'h55);
    chk("post-rst empty", empty0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
